// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with segmented carry chain, valid/ready handshake and
// carry / signed-overflow / zero flags registered alongside the final sum.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);
   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   function automatic logic signed_ovf(input logic sign_a, input logic sign_b,
                                       input logic sign_r);
      return (sign_a == sign_b) && (sign_r != sign_a);
   endfunction

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int IW = WIDTH - k*SEG;   // operand bits not yet added
      logic [IW-1:0]         a_in, b_in;
      logic                  c_in, sa_in, sb_in, v_in;
      logic [SEG:0]          seg_sum;
      logic [(k+1)*SEG-1:0]  res_nxt, res_p;
      logic                  cy_p, vld_p;

      if (k == 0) begin : g_src
         assign a_in    = a;
         assign b_in    = op_sub ? ~b : b;
         assign c_in    = op_sub;
         assign v_in    = in_valid;
         assign sa_in   = a[WIDTH-1];
         assign sb_in   = b_in[IW-1];
         assign res_nxt = seg_sum[SEG-1:0];
      end else begin : g_src
         assign a_in    = g_stage[k-1].g_fwd.a_p;
         assign b_in    = g_stage[k-1].g_fwd.b_p;
         assign c_in    = g_stage[k-1].cy_p;
         assign v_in    = g_stage[k-1].vld_p;
         assign sa_in   = g_stage[k-1].g_fwd.sa_p;
         assign sb_in   = g_stage[k-1].g_fwd.sb_p;
         assign res_nxt = {seg_sum[SEG-1:0], g_stage[k-1].res_p};
      end

      assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

      // stage k register boundary: result so far, segment carry, valid
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_p <= 1'b0;
            cy_p  <= 1'b0;
            res_p <= '0;
         end else if (adv) begin
            vld_p <= v_in;
            cy_p  <= seg_sum[SEG];
            res_p <= res_nxt;
         end
      end

      if (k < LAST) begin : g_fwd
         logic [IW-SEG-1:0] a_p, b_p;
         logic              sa_p, sb_p;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_p  <= '0;
               b_p  <= '0;
               sa_p <= 1'b0;
               sb_p <= 1'b0;
            end else if (adv) begin
               a_p  <= a_in[IW-1:SEG];
               b_p  <= b_in[IW-1:SEG];
               sa_p <= sa_in;
               sb_p <= sb_in;
            end
         end
      end
   end

   // final stage boundary: flags registered with the completed sum
   logic ovf_p, zero_p;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_p  <= 1'b0;
         zero_p <= 1'b0;
      end else if (adv) begin
         ovf_p  <= signed_ovf(g_stage[LAST].sa_in, g_stage[LAST].sb_in,
                              g_stage[LAST].res_nxt[WIDTH-1]);
         zero_p <= ~|g_stage[LAST].res_nxt;
      end
   end

   assign sum       = g_stage[LAST].res_p;
   assign carry     = g_stage[LAST].cy_p;
   assign out_valid = g_stage[LAST].vld_p;
   assign overflow  = ovf_p;
   assign zero      = zero_p;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: three parameterisations (32/2, 16/4, 8/1)
// driven by directed vectors; a negedge monitor pops and compares each result.
module tb_pipelined_adder;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid0, in_ready0, sub0, out_valid0, out_ready0, carry0, overflow0, zero0;
   logic [31:0] a0, b0, sum0;
   logic        in_valid1, in_ready1, sub1, out_valid1, out_ready1, carry1, overflow1, zero1;
   logic [15:0] a1, b1, sum1;
   logic        in_valid2, in_ready2, sub2, out_valid2, out_ready2, carry2, overflow2, zero2;
   logic [7:0]  a2, b2, sum2;

   pipelined_adder #(.WIDTH(32), .STAGES(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
      .op_sub(sub0), .out_valid(out_valid0), .out_ready(out_ready0), .sum(sum0),
      .carry(carry0), .overflow(overflow0), .zero(zero0));
   pipelined_adder #(.WIDTH(16), .STAGES(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
      .op_sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
      .carry(carry1), .overflow(overflow1), .zero(zero1));
   pipelined_adder #(.WIDTH(8), .STAGES(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
      .op_sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2),
      .carry(carry2), .overflow(overflow2), .zero(zero2));

   typedef struct packed {
      logic [31:0] sum;
      logic        c;
      logic        o;
      logic        z;
      logic        lat;
      logic [31:0] acc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   int passed = 0;
   int total  = 0;
   int ocnt[3];
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int stg(int id);
      return (id == 0) ? 2 : (id == 1) ? 4 : 1;
   endfunction

   function automatic logic rdy(int id);
      return (id == 0) ? in_ready0 : (id == 1) ? in_ready1 : in_ready2;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: actual %0h required %0h", name, act, req);
   endtask

   task automatic score(int id, logic [31:0] s, logic c, logic o, logic z);
      exp_t e;
      int   n;
      n = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
      if (n == 0) begin
         total++;
         $display("FAIL spurious_out%0d: actual sum %0h with nothing pending, required no output", id, s);
         return;
      end
      case (id)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
      ocnt[id]++;
      check($sformatf("result%0d", id), {s, c, o, z}, {e.sum, e.c, e.o, e.z});
      if (e.lat) check($sformatf("latency%0d", id), 64'(cyc - int'(e.acc)), 64'(stg(id) - 1));
   endtask

   always @(negedge clk) begin
      if (out_valid0 && out_ready0) score(0, sum0, carry0, overflow0, zero0);
      if (out_valid1 && out_ready1) score(1, {16'h0, sum1}, carry1, overflow1, zero1);
      if (out_valid2 && out_ready2) score(2, {24'h0, sum2}, carry2, overflow2, zero2);
   end

   task automatic send(int id, logic [31:0] av, logic [31:0] bv, logic sub,
                       logic [31:0] es, logic ec, logic eo, logic ez, logic lat);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      e  = '{sum: es, c: ec, o: eo, z: ez, lat: lat, acc: 32'd0};
      case (id)
         0:       begin a0 = av;       b0 = bv;       sub0 = sub; in_valid0 = 1'b1; end
         1:       begin a1 = av[15:0]; b1 = bv[15:0]; sub1 = sub; in_valid1 = 1'b1; end
         default: begin a2 = av[7:0];  b2 = bv[7:0];  sub2 = sub; in_valid2 = 1'b1; end
      endcase
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rdy(id)) begin
            e.acc = 32'(cyc + 1);
            case (id)
               0:       q0.push_back(e);
               1:       q1.push_back(e);
               default: q2.push_back(e);
            endcase
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         $display("FAIL send_timeout%0d: actual in_ready 0 for 40 cycles, required 1", id);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle_all();
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      in_valid2 = 1'b0;
   endtask

   task automatic drain();
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      logic [34:0] frz;
      int          base;
      bit          got;
      rst_n = 1'b0;
      {in_valid0, sub0, a0, b0} = '0;
      {in_valid1, sub1, a1, b1} = '0;
      {in_valid2, sub2, a2, b2} = '0;
      out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", {out_valid0, out_valid1, out_valid2}, 3'b000);
      check("reset_sum0", sum0, 32'h0);
      check("reset_flags0", {carry0, overflow0, zero0}, 3'b000);
      check("reset_sum12", {sum1, sum2}, 24'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_reset", in_ready0, 1'b1);

      send(0, 32'h65654540, 32'h80000001, 1'b0, 32'hE5654541, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_all(); drain();
      send(0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1);
      idle_all(); drain();
      send(0, 32'h80000000, 32'h00000007, 1'b0, 32'h80000007, 1'b0, 1'b0, 1'b0, 1'b1);
      send(0, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
      send(0, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
      send(0, 32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_all(); drain();
      check("count_directed", ocnt[0], 6);

      // backpressure: four ops, output held for three cycles once valid appears
      base = ocnt[0];
      fork
         begin
            send(0, 32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0);
            send(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
            send(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
            send(0, 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
            idle_all();
         end
         begin
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
               @(posedge clk); #1;
               if (out_valid0) begin got = 1'b1; break; end
            end
            check("bp_valid_seen", got, 1'b1);
            out_ready0 = 1'b0;
            frz = {sum0, carry0, overflow0, zero0};
            repeat (3) begin
               @(posedge clk); #1;
               check("bp_in_ready", in_ready0, 1'b0);
               check("bp_hold", {out_valid0, sum0, carry0, overflow0, zero0}, {1'b1, frz});
            end
            out_ready0 = 1'b1;
         end
      join
      drain();
      check("bp_count", ocnt[0] - base, 4);
      check("bp_queue_empty", q0.size(), 0);

      // reset with two operations in flight
      send(0, 32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0);
      send(0, 32'h00000040, 32'h00000050, 1'b0, 32'h00000090, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_all();
      #1;
      check("rst_pre_valid", out_valid0, 1'b1);
      base  = ocnt[0];
      rst_n = 1'b0;
      #1;
      check("rst_async_valid", out_valid0, 1'b0);
      check("rst_async_data", {sum0, carry0, overflow0, zero0}, 35'h0);
      q0.delete();
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("rst_no_stale", ocnt[0] - base, 0);
      check("rst_in_ready", in_ready0, 1'b1);

      send(1, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
      send(1, 32'h00007FFF, 32'h00000001, 1'b0, 32'h00008000, 1'b0, 1'b1, 1'b0, 1'b1);
      idle_all(); drain();
      send(2, 32'h0000007F, 32'h00000001, 1'b0, 32'h00000080, 1'b0, 1'b1, 1'b0, 1'b1);
      send(2, 32'h00000000, 32'h00000001, 1'b1, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_all(); drain();
      check("count_w16", ocnt[1], 2);
      check("count_w8", ocnt[2], 2);
      check("queues_empty", q0.size() + q1.size() + q2.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
